// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_master_param
// Description : Parameterised SPI master supporting all four SPI modes.
//               A transfer shifts out DATA_WIDTH bits on MOSI while sampling
//               the same number of bits from MISO. The bit rate is set by
//               CLK_DIV, and one of NUM_SS active-low slave selects is
//               driven for the duration of the transfer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : bits per transfer (2..32)
//   CLK_DIV    : clk cycles per SCLK half-period (1..255)
//   NUM_SS     : number of slave-select lines (1..16)
// Ports
//   clk        : in  - sole clock, rising edge
//   reset      : in  - asynchronous active-low reset
//   start      : in  - transfer request, honoured only when idle
//   din        : in  - transmit word, captured on the accepting edge
//   mode       : in  - {CPOL, CPHA}, captured on the accepting edge
//   ss_sel     : in  - target slave index, captured on the accepting edge
//   lsb_first  : in  - LSB-first order (present only with the macro below)
//   MISO       : in  - serial data from the slave
//   MOSI       : out - serial data to the slave
//   SCLK       : out - serial clock, idles at CPOL
//   SS         : out - active-low slave selects
//   dout       : out - last received word, updated once per transfer
//   busy       : out - high whenever a transfer is in progress
//   done       : out - one-cycle completion pulse
// Build option
//   SPI_MASTER_LSB_FIRST_EN : adds the lsb_first port. Without it every
//                             transfer is MSB first.
// ============================================================================
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int NUM_SS     = 4,
    localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [1:0]            mode,
    input  logic [SS_W-1:0]       ss_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    input  logic                  MISO,
    output logic                  MOSI,
    output logic                  SCLK,
    output logic [NUM_SS-1:0]     SS,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done
);

    // Divider counts 0..CLK_DIV, edge counter counts 0..2*DATA_WIDTH.
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);
    localparam logic [SS_W:0]    SS_LIMIT  = (SS_W + 1)'(NUM_SS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [DIV_W-1:0]        div_q,      div_d;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_q,       tx_d;
    logic [DATA_WIDTH-1:0]   rx_q,       rx_d;
    logic [DATA_WIDTH-1:0]   dout_q,     dout_d;
    logic                    mosi_q,     mosi_d;
    logic                    sclk_q,     sclk_d;
    logic [NUM_SS-1:0]       ss_q,       ss_d;
    logic                    cpha_q,     cpha_d;
    logic [SS_W-1:0]         sel_q,      sel_d;

    logic                    start_ok;
    logic                    div_hit;
    logic                    sclk_edge;
    logic                    odd_edge;
    logic [NUM_SS-1:0]       ss_sel_mask;
    logic [DATA_WIDTH-1:0]   tx_load;
    logic [DATA_WIDTH-1:0]   rx_word;

    // ------------------------------------------------------------------------
    // Bit-order handling. The shift engine is always MSB first; LSB-first
    // transfers are obtained by reversing the word on load and on unload,
    // which puts din[0] on the wire first and the first received bit in
    // dout[0].
    // ------------------------------------------------------------------------
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q, lsb_d;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = v[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    always_comb begin
        tx_load = lsb_first ? bit_rev(din)  : din;
        rx_word = lsb_q     ? bit_rev(rx_q) : rx_q;
    end
`else
    always_comb begin
        tx_load = din;
        rx_word = rx_q;
    end
`endif

    // Out-of-range slave indices are refused outright rather than aliased.
    assign start_ok    = start && ({1'b0, ss_sel} < SS_LIMIT);
    assign ss_sel_mask = ~(NUM_SS'(1) << sel_q);

    // An SCLK edge is due when the divider reaches CLK_DIV while the clock
    // is running (LEAD produces edge 1, SHIFT produces edges 2..2N).
    assign div_hit   = (div_q == DIV_MAX);
    assign sclk_edge = div_hit && ((state_q == ST_LEAD) || (state_q == ST_SHIFT));
    // edge_cnt_q holds the number of edges already produced, so the edge
    // about to happen is odd when that count is even.
    assign odd_edge  = ~edge_cnt_q[0];

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        ss_d       = ss_q;
        cpha_d     = cpha_q;
        sel_d      = sel_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // SCLK tracks the requested polarity so it already sits at
                // CPOL when a transfer begins.
                sclk_d = mode[1];
                mosi_d = 1'b0;
                ss_d   = '1;
                div_d  = '0;
                if (start_ok) begin
                    state_d    = ST_LEAD;
                    edge_cnt_d = '0;
                    tx_d       = tx_load;
                    rx_d       = '0;
                    cpha_d     = mode[0];
                    sel_d      = ss_sel;
`ifdef SPI_MASTER_LSB_FIRST_EN
                    lsb_d      = lsb_first;
`endif
                end
            end

            ST_LEAD: begin
                div_d = div_q + DIV_W'(1);
                // First LEAD cycle: select the slave and, in CPHA=0, put the
                // first bit out so it is stable before the sampling edge.
                if (div_q == '0) begin
                    ss_d = ss_sel_mask;
                    if (!cpha_q) begin
                        mosi_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end
                end
            end

            ST_SHIFT: begin
                div_d = div_q + DIV_W'(1);
            end

            ST_TRAIL: begin
                div_d = div_q + DIV_W'(1);
                // Half a period after the last edge the slave is released
                // and the received word is published.
                if (div_hit) begin
                    state_d = ST_DONE;
                    div_d   = '0;
                    ss_d    = '1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_word;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                ss_d    = '1;
                mosi_d  = 1'b0;
            end
        endcase

        // Shared SCLK edge handling for LEAD and SHIFT.
        if (sclk_edge) begin
            sclk_d     = ~sclk_q;
            div_d      = DIV_W'(1);
            edge_cnt_d = edge_cnt_q + CNT_W'(1);

            if (odd_edge) begin
                if (cpha_q) begin
                    mosi_d = tx_q[DATA_WIDTH-1];
                    tx_d   = tx_q << 1;
                end else begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], MISO};
                end
            end else begin
                if (cpha_q) begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], MISO};
                end else if (edge_cnt_q != LAST_EDGE) begin
                    // No shift after the final edge: all N bits are out.
                    mosi_d = tx_q[DATA_WIDTH-1];
                    tx_d   = tx_q << 1;
                end
            end

            state_d = (edge_cnt_q == LAST_EDGE) ? ST_TRAIL : ST_SHIFT;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            dout_q     <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ss_q       <= '1;
            cpha_q     <= 1'b0;
            sel_q      <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            dout_q     <= dout_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            cpha_q     <= cpha_d;
            sel_q      <= sel_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MOSI = mosi_q;
    assign SCLK = sclk_q;
    assign SS   = ss_q;
    assign dout = dout_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_param
// Description : Self-checking bench for spi_master_param. Table-driven
//               transfers on a default instance plus directed sequences for
//               slave-index rejection, reset abort and a 16-bit fast build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // ---------------- default instance (8 bit, div 4, 4 slaves) -------------
    logic       start;
    logic [7:0] din;
    logic [1:0] mode;
    logic [1:0] ss_sel;
    logic       miso, mosi, sclk, busy, done;
    logic [3:0] ss;
    logic [7:0] dout;
    logic       loop_en, slv_miso;
    assign miso = loop_en ? mosi : slv_miso;

    // ---------------- three-slave instance -----------------------------------
    logic       start3;
    logic [1:0] ss_sel3;
    logic [7:0] din3  = 8'h55;
    logic [1:0] mode3 = 2'b00;
    logic       miso3 = 1'b0;
    logic       mosi3, sclk3, busy3, done3;
    logic [2:0] ss3;
    logic [7:0] dout3;

    // ---------------- 16-bit, div 1 instance ---------------------------------
    logic        start16;
    logic [15:0] din16;
    logic [1:0]  mode16 = 2'b00;
    logic [1:0]  ss_sel16 = 2'd0;
    logic        miso16, mosi16, sclk16, busy16, done16;
    logic [3:0]  ss16;
    logic [15:0] dout16;
    assign miso16 = mosi16;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_main = 1'b0;
    logic lsb3     = 1'b0;
    logic lsb16    = 1'b1;
`endif

    spi_master_param u_dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .mode(mode), .ss_sel(ss_sel),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_main),
`endif
        .MISO(miso), .MOSI(mosi), .SCLK(sclk), .SS(ss), .dout(dout), .busy(busy), .done(done)
    );

    spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(4), .NUM_SS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .din(din3), .mode(mode3), .ss_sel(ss_sel3),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb3),
`endif
        .MISO(miso3), .MOSI(mosi3), .SCLK(sclk3), .SS(ss3), .dout(dout3), .busy(busy3), .done(done3)
    );

    spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(1), .NUM_SS(4)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .din(din16), .mode(mode16), .ss_sel(ss_sel16),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb16),
`endif
        .MISO(miso16), .MOSI(mosi16), .SCLK(sclk16), .SS(ss16), .dout(dout16), .busy(busy16), .done(done16)
    );

    // ---------------- checking ----------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic [1:0] sel;
        logic       loopback;
        logic [7:0] slave;
        logic       inject;
        logic [7:0] exp_dout;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs [7];

    // Measurements of the most recent transfer.
    logic [7:0] r_mosi, r_dout_done, r_dout_mid;
    int         r_edges, r_done, r_done_cnt, r_ss_first, r_ss_last, r_ss_bad;
    logic       r_sclk_pre, r_sclk_end, r_busy_mid, r_busy_post;
    logic [7:0] exp_prev;

    // Runs one transfer on the default instance. The bench plays the slave:
    // for CPHA=0 it presents its MSB once SS falls and changes on even edges,
    // for CPHA=1 it changes on odd edges. MOSI is captured on the master's
    // sampling edges from the value seen before the edge.
    task automatic run_xfer(input vec_t v);
        logic [3:0] lo_mask;
        logic       prev_sclk, prev_mosi, cpha;
        int         idx, e;
        cpha        = v.mode[0];
        lo_mask     = ~(4'b0001 << v.sel);
        r_mosi      = '0;
        r_edges     = 0;
        r_done      = -1;
        r_done_cnt  = 0;
        r_ss_first  = -1;
        r_ss_last   = -1;
        r_ss_bad    = 0;
        r_dout_done = 'x;
        r_dout_mid  = 'x;
        r_busy_mid  = 1'bx;
        r_sclk_end  = 1'bx;
        @(negedge clk);
        mode     = v.mode;
        ss_sel   = v.sel;
        din      = v.din;
        loop_en  = v.loopback;
        slv_miso = 1'b0;
        @(negedge clk);
        r_sclk_pre = sclk;
        start = 1'b1;
        @(negedge clk);                    // edge k has passed
        start  = 1'b0;
        din    = ~v.din;
        mode   = ~v.mode;
        ss_sel = v.sel ^ 2'b01;
        prev_sclk = sclk;
        prev_mosi = mosi;
        idx = 7;
        e   = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (ss == lo_mask) begin
                if (r_ss_first < 0) r_ss_first = c;
                r_ss_last = c;
            end else if (ss != 4'hF) begin
                r_ss_bad++;
            end
            if (c == 1 && !cpha && !v.loopback) begin
                slv_miso = v.slave[7];
                idx = 6;
            end
            if (r_done < 0 && sclk != prev_sclk) begin
                e++;
                if (cpha ? (e % 2 == 0) : (e % 2 == 1)) r_mosi = {r_mosi[6:0], prev_mosi};
                if (!v.loopback && (cpha ? (e % 2 == 1) : (e % 2 == 0 && e < 16))) begin
                    slv_miso = v.slave[idx];
                    idx--;
                end
            end
            if (c == 30) begin
                r_dout_mid = dout;
                r_busy_mid = busy;
                if (v.inject) start = 1'b1;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done < 0) begin
                    r_done      = c;
                    r_sclk_end  = sclk;
                    r_dout_done = dout;
                    if (v.inject) start = 1'b1;
                end
            end
            prev_sclk   = sclk;
            prev_mosi   = mosi;
            r_edges     = e;
            r_busy_post = busy;
            if (r_done >= 0 && c >= r_done + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input vec_t v);
        check({tag, " sclk_idle_before"}, r_sclk_pre, v.mode[1]);
        check({tag, " ss_first_low"},     r_ss_first, 1);
        check({tag, " ss_last_low"},      r_ss_last, 68);
        check({tag, " ss_other_bits"},    r_ss_bad, 0);
        check({tag, " sclk_edges"},       r_edges, 16);
        check({tag, " mosi_word"},        r_mosi, v.exp_mosi);
        check({tag, " done_cycle"},       r_done, 69);
        check({tag, " done_pulses"},      r_done_cnt, 1);
        check({tag, " sclk_idle_after"},  r_sclk_end, v.mode[1]);
        check({tag, " dout"},             r_dout_done, v.exp_dout);
        check({tag, " dout_held"},        r_dout_mid, exp_prev);
        check({tag, " busy_mid"},         r_busy_mid, 1'b1);
        check({tag, " busy_after"},       r_busy_post, 1'b0);
    endtask

    initial begin
        int         n_done, n_busy, n_edges;
        logic       bad3, p_sclk, p_mosi;
        logic [15:0] cap16, din16_val;
        int         done16_c;

        //                din    mode  sel  lp    slave  inj   dout   mosi
        vecs[0] = '{8'hA5, 2'd0, 2'd0, 1'b0, 8'h3C, 1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{8'hC3, 2'd1, 2'd0, 1'b1, 8'h00, 1'b0, 8'hC3, 8'hC3};
        vecs[2] = '{8'hC3, 2'd2, 2'd0, 1'b1, 8'h00, 1'b0, 8'hC3, 8'hC3};
        vecs[3] = '{8'hC3, 2'd3, 2'd0, 1'b1, 8'h00, 1'b1, 8'hC3, 8'hC3};
        vecs[4] = '{8'h5A, 2'd1, 2'd3, 1'b0, 8'h96, 1'b0, 8'h96, 8'h5A};
        vecs[5] = '{8'h81, 2'd2, 2'd2, 1'b0, 8'h7E, 1'b0, 8'h7E, 8'h81};
        vecs[6] = '{8'hFF, 2'd3, 2'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF};

        start = 0; din = 0; mode = 0; ss_sel = 0; loop_en = 0; slv_miso = 0;
        start3 = 0; ss_sel3 = 0; start16 = 0; din16 = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #10;
        check("reset SS",   ss,   4'hF);
        check("reset SCLK", sclk, 1'b0);
        check("reset MOSI", mosi, 1'b0);
        check("reset dout", dout, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        exp_prev = 8'h00;
        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i]);
            check_xfer($sformatf("vec%0d", i), vecs[i]);
            exp_prev = vecs[i].exp_dout;
        end

        // ---- slave index out of range is refused; a legal one is accepted --
        @(negedge clk);
        ss_sel3 = 2'd3;
        start3  = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        bad3 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy3 || ss3 != 3'b111) bad3 = 1'b1;
            @(negedge clk);
        end
        check("ss_sel out of range ignored", bad3, 1'b0);
        ss_sel3 = 2'd2;
        start3  = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("ss_sel 2 accepted busy", busy3, 1'b1);
        @(negedge clk);
        check("ss_sel 2 only SS[2] low", ss3, 3'b011);

        // ---- reset in the middle of a CPOL=1 transfer ---------------------
        @(negedge clk);
        mode = 2'b10; ss_sel = 2'd0; din = 8'h12; loop_en = 1'b0; slv_miso = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort busy before reset", busy, 1'b1);
        check("abort SCLK before reset", sclk, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort SS",   ss,   4'hF);
        check("abort SCLK", sclk, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort dout", dout, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("resume SCLK follows CPOL", sclk, 1'b1);
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < 100; c++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            @(negedge clk);
        end
        check("abort no done pulse", n_done, 0);
        check("abort stays idle",    n_busy, 0);
        exp_prev = 8'h00;
        run_xfer(vecs[1]);
        check_xfer("resume", vecs[1]);

        // ---- 16-bit, CLK_DIV=1 instance, loopback --------------------------
`ifdef SPI_MASTER_LSB_FIRST_EN
        din16_val = 16'h0001;
`else
        din16_val = 16'h8000;
`endif
        @(negedge clk);
        din16   = din16_val;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        p_sclk   = sclk16;
        p_mosi   = mosi16;
        cap16    = '0;
        n_edges  = 0;
        done16_c = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) check("w16 first MOSI bit", mosi16, 1'b1);
            if (done16_c < 0 && sclk16 != p_sclk) begin
                n_edges++;
                if (n_edges % 2 == 1) cap16 = {cap16[14:0], p_mosi};
            end
            if (done16 && done16_c < 0) begin
                done16_c = c;
                check("w16 dout", dout16, din16_val);
            end
            p_sclk = sclk16;
            p_mosi = mosi16;
            if (done16_c >= 0 && c >= done16_c + 2) break;
        end
        check("w16 done cycle",    done16_c, 34);
        check("w16 sclk edges",    n_edges, 32);
        check("w16 wire order",    cap16, 16'h8000);
        check("w16 busy after",    busy16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
